// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 / stride-2 max-pool over raster-order multi-channel pixel vectors.
// Horizontal pairs are reduced through a hold register, vertical pairs through a half-width line buffer.
module maxpool2x2_stream #(
  parameter int unsigned CH    = 16,
  parameter int unsigned DW    = 32,
  parameter int unsigned IMG_W = 24,
  parameter int unsigned IMG_H = 24,
  parameter int unsigned RELU  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CH*DW-1:0] data_in,
  input  logic             data_in_valid,
  output logic [CH*DW-1:0] data_out,
  output logic             data_out_valid,
  output logic             frame_done
);

  localparam int unsigned CW  = $clog2(IMG_W);
  localparam int unsigned RW  = $clog2(IMG_H);
  localparam int unsigned LB  = IMG_W / 2;
  localparam int unsigned LBW = (LB > 1) ? $clog2(LB) : 1;

  localparam logic [CW-1:0] ColLast     = CW'(IMG_W - 1);
  localparam logic [CW-1:0] ColPoolLast = CW'(2 * (IMG_W / 2) - 1);
  localparam logic [RW-1:0] RowLast     = RW'(IMG_H - 1);
  localparam logic [RW-1:0] RowPoolLast = RW'(2 * (IMG_H / 2) - 1);

  logic [CW-1:0]    col_q;
  logic [RW-1:0]    row_q;
  logic [CH*DW-1:0] hold_q;
  logic [CH*DW-1:0] dout_q;
  logic             valid_q;
  logic             fd_q;

  logic [CH*DW-1:0] linebuf [LB];

  logic [LBW-1:0]   lb_idx;
  logic [CH*DW-1:0] lb_rd;
  logic [CH*DW-1:0] hmax;
  logic [CH*DW-1:0] vmax;
  logic [CH*DW-1:0] res;
  logic             in_rows;
  logic             in_cols;
  logic             hold_we;
  logic             lb_we;
  logic             emit;
  logic             last_win;

  always_comb begin
    lb_idx = LBW'(col_q >> 1);
    lb_rd  = linebuf[lb_idx];
    hmax   = '0;
    vmax   = '0;
    res    = '0;
    for (int k = 0; k < CH; k++) begin
      hmax[k*DW +: DW] = ($signed(hold_q[k*DW +: DW]) > $signed(data_in[k*DW +: DW])) ?
                         hold_q[k*DW +: DW] : data_in[k*DW +: DW];
    end
    for (int k = 0; k < CH; k++) begin
      vmax[k*DW +: DW] = ($signed(lb_rd[k*DW +: DW]) > $signed(hmax[k*DW +: DW])) ?
                         lb_rd[k*DW +: DW] : hmax[k*DW +: DW];
    end
    for (int k = 0; k < CH; k++) begin
      res[k*DW +: DW] = ((RELU != 0) && vmax[k*DW + DW - 1]) ? '0 : vmax[k*DW +: DW];
    end
  end

  // Trailing odd row/column is counted but never pooled.
  always_comb begin
    in_rows  = ((IMG_H % 2) == 0) || (row_q != RowLast);
    in_cols  = ((IMG_W % 2) == 0) || (col_q != ColLast);
    hold_we  = data_in_valid && !col_q[0] && in_cols;
    lb_we    = data_in_valid && in_rows && col_q[0] && !row_q[0];
    emit     = data_in_valid && in_rows && col_q[0] && row_q[0];
    last_win = (row_q == RowPoolLast) && (col_q == ColPoolLast);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      hold_q  <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      valid_q <= emit;
      fd_q    <= emit && last_win;
      if (emit) dout_q <= res;
      if (hold_we) hold_q <= data_in;
      if (data_in_valid) begin
        if (col_q == ColLast) begin
          col_q <= '0;
          row_q <= (row_q == RowLast) ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

  // Not reset: each entry is written on an even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (lb_we) linebuf[lb_idx] <= hmax;
  end

  assign data_out       = dout_q;
  assign data_out_valid = valid_q;
  assign frame_done     = fd_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Scoreboard bench: three pooling instances (4x4, 4x4 with ReLU, 5x5), CH=2, DW=16.
// Stimulus pushes hand-computed expectations; a negedge monitor pops and compares.
module tb_maxpool2x2_stream;

  typedef struct {
    logic [31:0] data;
    logic        fd;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] din = '0;
  logic        vin = 1'b0;
  logic [31:0] din5 = '0;
  logic        vin5 = 1'b0;
  logic [2:0]  ov;
  logic [2:0]  ofd;
  logic [31:0] od [3];

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   n_fd [3] = '{0, 0, 0};
  int   exp_fd [3] = '{0, 0, 0};
  int   drain_seq = 0;
  int   drain_seen = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int br4 [4] = '{5, 7, 13, 15};
  int tl4 [4] = '{0, 2, 8, 10};
  int br5 [4] = '{6, 8, 16, 18};
  int tl5 [4] = '{0, 2, 10, 12};

  maxpool2x2_stream #(.CH(2), .DW(16), .IMG_W(4), .IMG_H(4), .RELU(0)) u_a (
    .clk(clk), .rst_n(rst_n), .data_in(din), .data_in_valid(vin),
    .data_out(od[0]), .data_out_valid(ov[0]), .frame_done(ofd[0]));

  maxpool2x2_stream #(.CH(2), .DW(16), .IMG_W(4), .IMG_H(4), .RELU(1)) u_r (
    .clk(clk), .rst_n(rst_n), .data_in(din), .data_in_valid(vin),
    .data_out(od[1]), .data_out_valid(ov[1]), .frame_done(ofd[1]));

  maxpool2x2_stream #(.CH(2), .DW(16), .IMG_W(5), .IMG_H(5), .RELU(0)) u_o (
    .clk(clk), .rst_n(rst_n), .data_in(din5), .data_in_valid(vin5),
    .data_out(od[2]), .data_out_valid(ov[2]), .frame_done(ofd[2]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int qsize(input int i);
    case (i)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t qpop(input int i);
    case (i)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic push(input int i, input logic [31:0] d, input logic fd);
    exp_t e;
    e.data = d;
    e.fd   = fd;
    e.cyc  = cyc + 1;
    case (i)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        checks++;
        if (ov[i] !== 1'b0 || ofd[i] !== 1'b0 || od[i] !== 32'h0) begin
          failures++;
          $display("FAIL reset_out[%0d] got v=%0b fd=%0b d=%h, want 0/0/0", i, ov[i], ofd[i],
                   od[i]);
        end
      end else if (ov[i] === 1'b1) begin
        checks++;
        if (qsize(i) == 0) begin
          failures++;
          $display("FAIL unexpected_out[%0d] got d=%h fd=%0b, want no output", i, od[i], ofd[i]);
        end else begin
          e = qpop(i);
          if (od[i] !== e.data || ofd[i] !== e.fd || cyc != e.cyc) begin
            failures++;
            $display("FAIL pool_out[%0d] got d=%h fd=%0b cyc=%0d, want d=%h fd=%0b cyc=%0d", i,
                     od[i], ofd[i], cyc, e.data, e.fd, e.cyc);
          end
        end
        if (ofd[i] === 1'b1) n_fd[i]++;
      end else if (ofd[i] !== 1'b0) begin
        checks++;
        failures++;
        $display("FAIL stray_frame_done[%0d] got fd=%0b without valid, want 0", i, ofd[i]);
      end
    end
    if (drain_seq != drain_seen) begin
      drain_seen = drain_seq;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (qsize(i) != 0 || n_fd[i] != exp_fd[i]) begin
          failures++;
          $display("FAIL drain[%0d] got pending=%0d frame_done=%0d, want pending=0 frame_done=%0d",
                   i, qsize(i), n_fd[i], exp_fd[i]);
        end
      end
    end
  end

  function automatic logic [31:0] pix(input int mode, input int w, input int r, input int c);
    int          v;
    logic [15:0] a;
    logic [15:0] b;
    v = r * w + c;
    case (mode)
      0: begin a = 16'(v); b = 16'(-v); end
      1: begin a = 16'hfffd; b = 16'hfffd; end
      default: begin
        a = ((r + c) % 2 == 1) ? 16'h7fff : 16'h8000;
        b = ((r + c) % 2 == 1) ? 16'h8000 : 16'h7fff;
      end
    endcase
    return {b, a};
  endfunction

  // Drives the 4x4 pair (plain and ReLU); leaves vin high so frames can abut.
  task automatic frame4(input int mode, input bit gaps, input int nbeats);
    int r, c, k;
    for (int b = 0; b < nbeats; b++) begin
      r = b / 4;
      c = b % 4;
      @(negedge clk);
      vin = 1'b1;
      din = pix(mode, 4, r, c);
      if (r % 2 == 1 && c % 2 == 1) begin
        k = (r / 2) * 2 + c / 2;
        case (mode)
          0: begin
            push(0, {16'(-tl4[k]), 16'(br4[k])}, k == 3);
            push(1, {16'h0, 16'(br4[k])}, k == 3);
          end
          1: begin
            push(0, 32'hfffd_fffd, k == 3);
            push(1, 32'h0, k == 3);
          end
          default: begin
            push(0, 32'h7fff_7fff, k == 3);
            push(1, 32'h7fff_7fff, k == 3);
          end
        endcase
      end
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk);
          vin = 1'b0;
        end
      end
    end
  endtask

  task automatic frame5();
    int k;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        vin5 = 1'b1;
        din5 = pix(0, 5, r, c);
        if (r % 2 == 1 && c % 2 == 1 && r < 4 && c < 4) begin
          k = (r / 2) * 2 + c / 2;
          push(2, {16'(-tl5[k]), 16'(br5[k])}, k == 3);
        end
      end
    end
  endtask

  task automatic drain(input int fa, input int fr, input int fo);
    @(negedge clk);
    vin  = 1'b0;
    vin5 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    exp_fd[0] = fa;
    exp_fd[1] = fr;
    exp_fd[2] = fo;
    drain_seq++;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    frame4(0, 1'b0, 16);
    drain(1, 1, 0);
    frame4(1, 1'b0, 16);
    drain(2, 2, 0);
    frame4(2, 1'b0, 16);
    drain(3, 3, 0);
    frame4(0, 1'b1, 16);
    drain(4, 4, 0);
    frame4(0, 1'b0, 16);
    frame4(0, 1'b0, 16);
    frame4(0, 1'b0, 16);
    drain(7, 7, 0);
    frame5();
    frame5();
    drain(7, 7, 2);
    frame4(0, 1'b0, 9);
    @(negedge clk);
    vin = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    frame4(0, 1'b0, 16);
    drain(8, 8, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish by 200000, want finish");
    $fatal(1);
  end

endmodule
